uart_baud_gen: RTL and testbench

Programmable baud-rate tick generator for the UART. It replaces the fixed-divisor bit-clock generator with a runtime-loadable divisor, an oversampling tick for the receiver and a bit-centre sampling tick. It also has a phase-restart input so the receiver can align to a start-bit edge. It sits between the UART register interface (divisor source) and the TX/RX shift engines (tick consumers).

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_frac_acc.sv | 37 +++
 rtl/uart_baud_gen.sv | 163 ++++++++++++++++
 tb/tb_uart_baud_gen.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and elaboration helpers for the UART baud generator.
package uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < value) r = i + 1;
    return r;
  endfunction

  // Divisor in units of 1/2^frac_wd clock per oversample tick.
  function automatic longint div_rst(
    input longint clk_hz,
    input longint baud,
    input longint os,
    input int     frac_wd
  );
    return (clk_hz << frac_wd) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_frac_acc.sv
// uart_frac_acc: fractional divisor accumulator; carry stretches one period.
// Instantiated by uart_baud_gen only when UART_BAUD_FRAC_EN is defined.
module uart_frac_acc
  import uart_pkg::*;
#(
  parameter int FRAC_WD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               adv,
  input  logic [FRAC_WD-1:0] frac,
  output logic               carry
);

  logic [FRAC_WD-1:0] acc_q, acc_d;
  logic [FRAC_WD:0]   sum;

  // Carry belongs to the period now running, so it looks one add ahead.
  assign sum   = {1'b0, acc_q} + {1'b0, frac};
  assign carry = sum[FRAC_WD];

  always_comb begin
    acc_d = acc_q;
    unique case (1'b1)
      clr:     acc_d = '0;
      adv:     acc_d = sum[FRAC_WD-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: loadable-divisor baud tick generator (os/mid/bps ticks).
// Define UART_BAUD_FRAC_EN to enable the fractional divisor path.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WD     = 16,
  parameter int FRAC_WD    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               uart_en,
  input  logic [DIV_WD-1:0]  div_int,
  input  logic [FRAC_WD-1:0] div_frac,
  input  logic               div_load,
  input  logic               phase_rst,
  output logic               os_tick,
  output logic               mid_tick,
  output logic               bps_tick,
  output logic               div_err
);

  localparam int CW     = DIV_WD + 1;
  localparam int SUB_WD = clog2(OVERSAMPLE);

  localparam longint RST_Q = div_rst(CLK_FREQ, BAUD_RATE,
                                     OVERSAMPLE, FRAC_WD);

  localparam logic [DIV_WD-1:0] RST_INT =
    DIV_WD'(RST_Q >> FRAC_WD);

  localparam logic [SUB_WD-1:0] SUB_LAST =
    SUB_WD'(OVERSAMPLE - 1);
  localparam logic [SUB_WD-1:0] SUB_MID  =
    SUB_WD'(OVERSAMPLE / 2 - 1);

  localparam logic [DIV_WD-1:0] DIV_MIN = DIV_WD'(2);

  state_e state_q, state_d;

  logic [CW-1:0]     os_cnt_q, os_cnt_d;
  logic [CW-1:0]     period;
  logic [SUB_WD-1:0] sub_cnt_q, sub_cnt_d;
  logic [DIV_WD-1:0] div_act_q, div_act_d;
  logic [DIV_WD-1:0] sh_int_q, sh_int_d;
  logic [DIV_WD-1:0] src_int;
  logic              pend_q, pend_d;
  logic              err_q, err_d;
  logic              os_q, os_d;
  logic              mid_q, mid_d;
  logic              bps_q, bps_d;
  logic              active, imm, wrap, apply, carry;

  assign active = (state_q == RUN) && uart_en;
  assign imm    = !active || phase_rst;
  assign period = {1'b0, div_act_q} + {{DIV_WD{1'b0}}, carry};
  assign wrap   = active && !phase_rst &&
                  (os_cnt_q == period - CW'(1));

  // Shadow divisor lands at a tick boundary, or at once when not counting.
  assign apply   = (div_load || pend_q) && (imm || wrap);
  assign src_int = div_load ? div_int : sh_int_q;

`ifdef UART_BAUD_FRAC_EN
  localparam logic [FRAC_WD-1:0] RST_FRAC = FRAC_WD'(RST_Q);

  logic [FRAC_WD-1:0] frac_act_q, frac_act_d;
  logic [FRAC_WD-1:0] sh_frac_q, sh_frac_d;

  uart_frac_acc #(
    .FRAC_WD(FRAC_WD)
  ) u_frac (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (imm),
    .adv  (wrap),
    .frac (frac_act_q),
    .carry(carry)
  );

  always_comb begin
    sh_frac_d  = div_load ? div_frac : sh_frac_q;
    frac_act_d = frac_act_q;
    if (apply) frac_act_d = div_load ? div_frac : sh_frac_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frac_act_q <= RST_FRAC;
      sh_frac_q  <= RST_FRAC;
    end else begin
      frac_act_q <= frac_act_d;
      sh_frac_q  <= sh_frac_d;
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^div_frac;
  assign carry       = 1'b0;
`endif

  always_comb begin
    state_d   = uart_en ? RUN : IDLE;
    sh_int_d  = div_load ? div_int : sh_int_q;
    pend_d    = (div_load || pend_q) && !apply;
    err_d     = err_q || (div_load && (div_int < DIV_MIN));
    div_act_d = div_act_q;
    if (apply)
      div_act_d = (src_int < DIV_MIN) ? DIV_MIN : src_int;
    os_cnt_d  = os_cnt_q + CW'(1);
    sub_cnt_d = sub_cnt_q;
    os_d      = wrap;
    mid_d     = 1'b0;
    bps_d     = 1'b0;
    unique case (1'b1)
      imm: begin
        os_cnt_d  = '0;
        sub_cnt_d = '0;
      end
      wrap: begin
        os_cnt_d  = '0;
        bps_d     = (sub_cnt_q == SUB_LAST);
        mid_d     = (sub_cnt_q == SUB_MID);
        sub_cnt_d = bps_d ? '0 : sub_cnt_q + SUB_WD'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      os_cnt_q  <= '0;
      sub_cnt_q <= '0;
      div_act_q <= RST_INT;
      sh_int_q  <= RST_INT;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      os_q      <= 1'b0;
      mid_q     <= 1'b0;
      bps_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      sub_cnt_q <= sub_cnt_d;
      div_act_q <= div_act_d;
      sh_int_q  <= sh_int_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      os_q      <= os_d;
      mid_q     <= mid_d;
      bps_q     <= bps_d;
    end
  end

  assign os_tick  = os_q;
  assign mid_tick = mid_q;
  assign bps_tick = bps_q;
  assign div_err  = err_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: directed scenarios plus random traffic against an
// event-schedule model of tick times (next due cycle per period).
module tb_uart_baud_gen;

  localparam int CLK_FREQ   = 50_000_000;
  localparam int BAUD_RATE  = 9600;
  localparam int OVERSAMPLE = 16;
  localparam int DIV_WD     = 16;
  localparam int FRAC_WD    = 4;
  localparam int RST_Q      = (CLK_FREQ * (1 << FRAC_WD)) /
                              (BAUD_RATE * OVERSAMPLE);
  localparam int RST_INT    = RST_Q >> FRAC_WD;
  localparam int RST_FRAC   = RST_Q % (1 << FRAC_WD);

  logic               clk;
  logic               rst_n;
  logic               uart_en;
  logic [DIV_WD-1:0]  div_int;
  logic [FRAC_WD-1:0] div_frac;
  logic               div_load;
  logic               phase_rst;
  logic               os_tick;
  logic               mid_tick;
  logic               bps_tick;
  logic               div_err;

  uart_baud_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE),
    .DIV_WD    (DIV_WD),
    .FRAC_WD   (FRAC_WD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_en  (uart_en),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .phase_rst(phase_rst),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bps_tick (bps_tick),
    .div_err  (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  bit m_run, m_pend, m_err;
  int m_div, m_frac, m_shi, m_shf, m_acc, m_ticks, m_due;
  bit e_os, e_mid, e_bps;

  // Total cycles for n periods starting from a fresh phase.
  function automatic int span(input int n);
`ifdef UART_BAUD_FRAC_EN
    return n * RST_INT + (n * RST_FRAC) / (1 << FRAC_WD);
`else
    return n * RST_INT;
`endif
  endfunction

  function automatic int next_period();
`ifdef UART_BAUD_FRAC_EN
    return m_div + (((m_acc + m_frac) >= (1 << FRAC_WD)) ? 1 : 0);
`else
    return m_div;
`endif
  endfunction

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_err = 0;
    m_div = RST_INT; m_frac = RST_FRAC;
    m_shi = RST_INT; m_shf = RST_FRAC;
    m_acc = 0; m_ticks = 0; m_due = -1;
    e_os = 0; e_mid = 0; e_bps = 0;
  endtask

  task automatic model_apply();
    if (m_pend) begin
      m_div  = (m_shi < 2) ? 2 : m_shi;
      m_frac = m_shf;
      m_pend = 0;
    end
  endtask

  task automatic model_edge();
    bit act, tick;
    act  = m_run && uart_en;
    tick = act && !phase_rst && (cyc == m_due);
    if (div_load) begin
      m_shi  = int'(div_int);
      m_shf  = int'(div_frac);
      m_pend = 1;
      if (div_int < 2) m_err = 1;
    end
    e_os = tick; e_mid = 0; e_bps = 0;
    if (!act || phase_rst) begin
      m_ticks = 0;
      m_acc   = 0;
      model_apply();
    end else if (tick) begin
      m_ticks = (m_ticks + 1) % OVERSAMPLE;
      e_bps   = (m_ticks == 0);
      e_mid   = (m_ticks == OVERSAMPLE / 2);
      m_acc   = (m_acc + m_frac) % (1 << FRAC_WD);
      model_apply();
    end
    if (!act || phase_rst || tick) m_due = cyc + next_period();
    m_run = uart_en;
  endtask

  // One clock: advance the model and score every output against it.
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    n_cmp++;
    if ({os_tick, mid_tick, bps_tick, div_err} !==
        {e_os, e_mid, e_bps, m_err}) begin
      n_bad++;
      $display("FAIL model cyc=%0d os/mid/bps/err got=%b want=%b", cyc,
               {os_tick, mid_tick, bps_tick, div_err},
               {e_os, e_mid, e_bps, m_err});
    end
  endtask

  task automatic wait_sig(input int which, input int limit,
                          output int at);
    at = -1;
    for (int i = 0; i < limit && at < 0; i++) begin
      step();
      if ((which == 0 && os_tick) || (which == 1 && mid_tick) ||
          (which == 2 && bps_tick)) at = cyc;
    end
  endtask

  task automatic test_reset();
    rst_n = 0; uart_en = 0; div_int = '0; div_frac = '0;
    div_load = 0; phase_rst = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({os_tick, mid_tick, bps_tick, div_err} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outs got=%b want=0000",
               {os_tick, mid_tick, bps_tick, div_err});
    end
    rst_n = 1;
    repeat (3) step();
  endtask

  task automatic test_int_default();
    int e0, os1, os2, mid1, bps1;
    os1 = -1; os2 = -1; mid1 = -1; bps1 = -1;
    uart_en = 1;
    step();
    e0 = cyc;
    for (int i = 0; i < span(16) + 50; i++) begin
      step();
      if (os_tick) begin
        if (os1 < 0) os1 = cyc - e0;
        else if (os2 < 0) os2 = cyc - e0;
      end
      if (mid_tick && mid1 < 0) mid1 = cyc - e0;
      if (bps_tick && bps1 < 0) bps1 = cyc - e0;
    end
    n_cmp++;
    if (os1 !== span(1)) begin
      n_bad++;
      $display("FAIL first_os got=%0d want=%0d", os1, span(1));
    end
    n_cmp++;
    if (os2 - os1 !== span(2) - span(1)) begin
      n_bad++;
      $display("FAIL os_period got=%0d want=%0d", os2 - os1,
               span(2) - span(1));
    end
    n_cmp++;
    if (mid1 !== span(OVERSAMPLE / 2)) begin
      n_bad++;
      $display("FAIL first_mid got=%0d want=%0d", mid1,
               span(OVERSAMPLE / 2));
    end
    n_cmp++;
    if (bps1 !== span(OVERSAMPLE)) begin
      n_bad++;
      $display("FAIL first_bps got=%0d want=%0d", bps1,
               span(OVERSAMPLE));
    end
    uart_en = 0;
    step();
  endtask

  task automatic test_phase_rst();
    int t, p;
    div_int = 16'd100; div_frac = '0; div_load = 1;
    step();
    div_load = 0; uart_en = 1;
    step();
    wait_sig(0, 200, t);
    repeat (40) step();
    phase_rst = 1;
    step();
    p = cyc; phase_rst = 0;
    n_cmp++;
    if (os_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL phase40_no_tick got=%b want=0", os_tick);
    end
    wait_sig(1, 900, t);
    n_cmp++;
    if (t - p !== 800) begin
      n_bad++;
      $display("FAIL phase_mid_delay got=%0d want=800", t - p);
    end
    repeat (99) step();
    phase_rst = 1;
    step();
    p = cyc; phase_rst = 0;
    n_cmp++;
    if (os_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL phase_beats_tick got=%b want=0", os_tick);
    end
    wait_sig(0, 200, t);
    n_cmp++;
    if (t - p !== 100) begin
      n_bad++;
      $display("FAIL phase_next_os got=%0d want=100", t - p);
    end
  endtask

  task automatic test_midload();
    int t, t2, t3;
    wait_sig(0, 200, t);
    repeat (30) step();
    div_int = 16'd20; div_load = 1;
    step();
    div_load = 0;
    wait_sig(0, 200, t2);
    n_cmp++;
    if (t2 - t !== 100) begin
      n_bad++;
      $display("FAIL midload_old_period got=%0d want=100", t2 - t);
    end
    wait_sig(0, 50, t3);
    n_cmp++;
    if (t3 - t2 !== 20) begin
      n_bad++;
      $display("FAIL midload_new_period got=%0d want=20", t3 - t2);
    end
  endtask

  task automatic test_en_drop();
    int t, r;
    bit quiet;
    wait_sig(0, 50, t);
    repeat (7) step();
    uart_en = 0; quiet = 1;
    repeat (3) begin
      step();
      if (os_tick || mid_tick || bps_tick) quiet = 0;
    end
    n_cmp++;
    if (quiet !== 1'b1) begin
      n_bad++;
      $display("FAIL en_low_quiet got=%b want=1", quiet);
    end
    uart_en = 1;
    step();
    r = cyc;
    wait_sig(0, 50, t);
    n_cmp++;
    if (t - r !== 20) begin
      n_bad++;
      $display("FAIL reentry_os got=%0d want=20", t - r);
    end
  endtask

  task automatic test_div_err();
    int r, t1, t2;
    uart_en = 0;
    step();
    div_int = 16'd1; div_load = 1;
    step();
    div_load = 0;
    n_cmp++;
    if (div_err !== 1'b1) begin
      n_bad++;
      $display("FAIL div_err_set got=%b want=1", div_err);
    end
    uart_en = 1;
    step();
    r = cyc;
    wait_sig(0, 10, t1);
    wait_sig(0, 10, t2);
    n_cmp++;
    if (t1 - r !== 2 || t2 - t1 !== 2) begin
      n_bad++;
      $display("FAIL clamp_period got=%0d,%0d want=2,2", t1 - r, t2 - t1);
    end
    div_int = 16'd50; div_load = 1;
    step();
    div_load = 0;
    n_cmp++;
    if (div_err !== 1'b1) begin
      n_bad++;
      $display("FAIL div_err_sticky got=%b want=1", div_err);
    end
    wait_sig(0, 10, t1);
    wait_sig(0, 60, t2);
    n_cmp++;
    if (t2 - t1 !== 50) begin
      n_bad++;
      $display("FAIL reload_period got=%0d want=50", t2 - t1);
    end
  endtask

`ifdef UART_BAUD_FRAC_EN
  task automatic test_frac();
    int r, t, p1, p2;
    int ts[$];
    uart_en = 0;
    step();
    div_int = 16'd10; div_frac = 4'd8; div_load = 1;
    step();
    div_load = 0; uart_en = 1;
    step();
    r = cyc;
    repeat (16) begin
      wait_sig(0, 20, t);
      ts.push_back(t);
    end
    p1 = ts[0] - r;
    p2 = ts[1] - ts[0];
    n_cmp++;
    if (p1 !== 10 || p2 !== 11) begin
      n_bad++;
      $display("FAIL frac_alternate got=%0d,%0d want=10,11", p1, p2);
    end
    n_cmp++;
    if (ts[15] - r !== 168) begin
      n_bad++;
      $display("FAIL frac_span16 got=%0d want=168", ts[15] - r);
    end
    div_frac = '0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 4) uart_en = ~uart_en;
      else if (!uart_en && r < 40) uart_en = 1;
      div_load = (r >= 100 && r < 108);
      if (div_load) begin
        div_int  = ($urandom_range(0, 9) == 0) ?
                   16'($urandom_range(0, 1)) :
                   16'($urandom_range(2, 30));
        div_frac = 4'($urandom);
      end
      phase_rst = (r >= 200 && r < 205);
      step();
    end
    div_load = 0; phase_rst = 0;
  endtask

  task automatic test_async_reset();
    int t, r;
    uart_en = 0;
    step();
    div_int = 16'd2; div_frac = '0; div_load = 1;
    step();
    div_load = 0; uart_en = 1;
    step();
    wait_sig(0, 10, t);
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({os_tick, mid_tick, bps_tick, div_err} !== 4'b0000) begin
      n_bad++;
      $display("FAIL async_reset got=%b want=0000",
               {os_tick, mid_tick, bps_tick, div_err});
    end
    uart_en = 0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    step();
    uart_en = 1;
    step();
    r = cyc;
    wait_sig(0, RST_INT + 20, t);
    n_cmp++;
    if (t - r !== span(1)) begin
      n_bad++;
      $display("FAIL reset_divisor got=%0d want=%0d", t - r, span(1));
    end
  endtask

  initial begin
    test_reset();
    test_int_default();
    test_phase_rst();
    test_midload();
    test_en_drop();
    test_div_err();
`ifdef UART_BAUD_FRAC_EN
    test_frac();
`endif
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
